and_serial_ctrl: RTL and testbench

//  Sequencer sharing a single and_1_bit cell across WIDTH-bit operands, one bit per clock, LSB first.

---
 rtl/and_serial_ctrl_pkg.sv | 16 +
 rtl/and_serial_ctrl_if.sv | 21 ++
 rtl/and_1_bit.sv | 8 +
 rtl/and_serial_ctrl.sv | 87 ++++++++
 tb/tb_and_serial_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/and_serial_ctrl_pkg.sv
// Shared types and helpers for the bit-serial AND sequencer.
// State codes are a 2-bit binary encoding; 2'b11 is unused and recovers to IDLE.
package and_serial_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // A 1-bit operand still needs a 1-bit index register.
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/and_serial_ctrl_if.sv
// Request/result bus between a register-level requester and the serial AND sequencer.
interface and_serial_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] x_out;

    modport master (
        output start, a_in, b_in,
        input  busy, done, x_out
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, done, x_out
    );
endinterface

// File: rtl/and_1_bit.sv
// Single-bit AND datapath cell, time-shared across all operand bits.
module and_1_bit (
    input  logic A,
    input  logic B,
    output logic X
);
    assign X = A & B;
endmodule

// File: rtl/and_serial_ctrl.sv
// Sequencer that pushes WIDTH operand bit pairs through one and_1_bit cell, LSB first,
// then pulses done for one cycle. Result holds until the next accepted start or reset.
module and_serial_ctrl
    import and_serial_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    and_serial_ctrl_if.slave   bus
);

    localparam int             IDX_W    = idx_width(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic               cell_a, cell_b, cell_x;

    assign cell_a = a_q[idx_q];
    assign cell_b = b_q[idx_q];

    and_1_bit u_cell (
        .A (cell_a),
        .B (cell_b),
        .X (cell_x)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            x_q     <= x_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_RUN;
            ST_RUN:  if (idx_q == IDX_LAST) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Index stops at the last bit so it never wraps; it is reloaded on the next accept.
    always_comb begin
        idx_d = idx_q;
        a_d   = a_q;
        b_d   = b_q;
        x_d   = x_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d   = bus.a_in;
                    b_d   = bus.b_in;
                    x_d   = '0;
                    idx_d = '0;
                end
            end
            ST_RUN: begin
                x_d[idx_q] = cell_x;
                if (idx_q != IDX_LAST) idx_d = idx_q + IDX_W'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.busy  = (state_q == ST_RUN) || (state_q == ST_DONE);
        bus.done  = (state_q == ST_DONE);
        bus.x_out = x_q;
    end

endmodule

// File: tb/tb_and_serial_ctrl.sv
// Bench for and_serial_ctrl: table-driven jobs, hand sequences for the corner cases,
// and random traffic checked every cycle against a cycle-offset reference model.
module tb_and_serial_ctrl;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    and_serial_ctrl_if #(.WIDTH(8)) m_if ();
    and_serial_ctrl_if #(.WIDTH(1)) s_if ();

    and_serial_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(m_if));
    and_serial_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(s_if));

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a job accepted at edge acc finishes WIDTH edges later;
    // after edge acc+d the low d result bits are visible.
    int          cyc = 0;
    int          acc = 0;
    bit          job = 1'b0;
    bit          chk_en = 1'b0;
    logic [7:0]  res = 8'h00;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] a_run;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl [6];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        int         d;
        logic [7:0] ex;
        @(posedge clk);
        cyc++;
        if (rst) job = 1'b0;
        else if (m_if.start && !(job && (cyc - 1 - acc) <= W)) begin
            job = 1'b1;
            acc = cyc;
            res = m_if.a_in & m_if.b_in;
        end
        @(negedge clk);
        if (chk_en) begin
            d  = cyc - acc;
            ex = !job ? 8'h00 : ((d < W) ? (res & 8'((1 << d) - 1)) : res);
            cmp("model_busy", {31'd0, m_if.busy}, {31'd0, job && d <= W});
            cmp("model_done", {31'd0, m_if.done}, {31'd0, job && d == W});
            cmp("model_x", {24'd0, m_if.x_out}, {24'd0, ex});
        end
    endtask

    task automatic run_job(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] a_run, input logic [7:0] exp);
        int nb;
        m_if.a_in  = a;
        m_if.b_in  = b;
        m_if.start = 1'b1;
        tick();
        m_if.start = 1'b0;
        m_if.a_in  = a_run;
        m_if.b_in  = 8'($urandom);
        nb = m_if.busy ? 1 : 0;
        for (int i = 0; i < 20 && !m_if.done; i++) begin
            tick();
            if (m_if.busy) nb++;
        end
        cmp("done_seen", {31'd0, m_if.done}, 32'd1);
        cmp("busy_cycles", nb, 9);
        cmp("result", {24'd0, m_if.x_out}, {24'd0, exp});
        tick();
        cmp("idle_busy", {31'd0, m_if.busy}, 32'd0);
        cmp("held_x", {24'd0, m_if.x_out}, {24'd0, exp});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int dones;
        int last;

        tbl[0] = '{8'hF0, 8'h3C, 8'hF0, 8'h30};
        tbl[1] = '{8'hFF, 8'hA5, 8'h00, 8'hA5};
        tbl[2] = '{8'h0F, 8'hFF, 8'hF0, 8'h0F};
        tbl[3] = '{8'hAA, 8'h55, 8'hFF, 8'h00};
        tbl[4] = '{8'hFF, 8'hFF, 8'h00, 8'hFF};
        tbl[5] = '{8'h81, 8'hC3, 8'h7E, 8'h81};

        m_if.start = 1'b0; m_if.a_in = 8'h00; m_if.b_in = 8'h00;
        s_if.start = 1'b0; s_if.a_in = 1'b0;  s_if.b_in = 1'b0;

        // reset, then idle
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        cmp("rst_busy", {31'd0, m_if.busy}, 32'd0);
        cmp("rst_done", {31'd0, m_if.done}, 32'd0);
        cmp("rst_x", {24'd0, m_if.x_out}, 32'd0);
        cmp("rst_w1_busy", {31'd0, s_if.busy}, 32'd0);
        cmp("rst_w1_x", {31'd0, s_if.x_out}, 32'd0);
        rst = 1'b0;
        m_if.a_in = 8'hFF; m_if.b_in = 8'hFF;
        for (int i = 0; i < 3; i++) tick();
        cmp("idle_x", {24'd0, m_if.x_out}, 32'd0);

        // table of jobs; operands are scrambled while the job runs
        for (int i = 0; i < 6; i++) run_job(tbl[i].a, tbl[i].b, tbl[i].a_run, tbl[i].exp);

        // start held high: only accepted from IDLE, one done every WIDTH+2 cycles
        m_if.start = 1'b1;
        dones = 0;
        last  = -1;
        for (int i = 0; i < 40; i++) begin
            m_if.a_in = 8'($urandom);
            m_if.b_in = 8'($urandom);
            tick();
            if (m_if.done) begin
                if (last >= 0) cmp("held_interval", cyc - last, 10);
                dones++;
                last = cyc;
            end
        end
        m_if.start = 1'b0;
        cmp("held_done_count", dones, 4);
        tick();

        // reset in the middle of a job aborts it without a done pulse
        m_if.a_in = 8'hFF; m_if.b_in = 8'hFF; m_if.start = 1'b1;
        tick();
        m_if.start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp("abort_busy", {31'd0, m_if.busy}, 32'd0);
        cmp("abort_x", {24'd0, m_if.x_out}, 32'd0);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_if.done) dones++;
        end
        cmp("abort_no_done", dones, 0);
        run_job(8'h0F, 8'hFF, 8'h00, 8'h0F);

        // WIDTH=1 instance
        s_if.a_in = 1'b1; s_if.b_in = 1'b1; s_if.start = 1'b1;
        tick();
        s_if.start = 1'b0;
        cmp("w1_run_busy", {31'd0, s_if.busy}, 32'd1);
        cmp("w1_run_done", {31'd0, s_if.done}, 32'd0);
        tick();
        cmp("w1_done", {31'd0, s_if.done}, 32'd1);
        cmp("w1_x_11", {31'd0, s_if.x_out}, 32'd1);
        tick();
        cmp("w1_idle_busy", {31'd0, s_if.busy}, 32'd0);
        cmp("w1_hold_x", {31'd0, s_if.x_out}, 32'd1);
        s_if.a_in = 1'b0; s_if.b_in = 1'b1; s_if.start = 1'b1;
        tick();
        s_if.start = 1'b0;
        cmp("w1_clear_x", {31'd0, s_if.x_out}, 32'd0);
        tick();
        cmp("w1_done2", {31'd0, s_if.done}, 32'd1);
        cmp("w1_x_01", {31'd0, s_if.x_out}, 32'd0);
        tick();

        // random traffic with occasional resets, checked by the model every cycle
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 49) == 0);
            m_if.start = ($urandom_range(0, 2) == 0);
            m_if.a_in  = 8'($urandom);
            m_if.b_in  = 8'($urandom);
            tick();
        end
        rst = 1'b0;
        m_if.start = 1'b0;
        for (int i = 0; i < 12; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
